// File: rtl/riscv_main_decoder_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, ALU codes, operand/size/writeback
// selects, and the control bundle the decoder builds before driving its ports.
package riscv_main_decoder_pkg;

    localparam int ALU_CODE_WIDTH = 5;

    localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
    localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
    localparam logic [4:0] OPCODE_STORE    = 5'b01000;
    localparam logic [4:0] OPCODE_OP       = 5'b01100;
    localparam logic [4:0] OPCODE_LUI      = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
    localparam logic [4:0] OPCODE_JALR     = 5'b11001;
    localparam logic [4:0] OPCODE_JAL      = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

    localparam logic [1:0] OPCODE_TYPE_32BIT = 2'b11;

    localparam logic [6:0] FUNC7_BASE = 7'h00;
    localparam logic [6:0] FUNC7_ALT  = 7'h20;

    localparam logic [ALU_CODE_WIDTH-1:0] ALU_ADD  = 5'b00000;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_SLL  = 5'b00001;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_SLTS = 5'b00010;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_SLTU = 5'b00011;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_XOR  = 5'b00100;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_SRL  = 5'b00101;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_OR   = 5'b00110;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_AND  = 5'b00111;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_SUB  = 5'b01000;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_SRA  = 5'b01101;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_EQ   = 5'b11000;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_NE   = 5'b11001;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_LTS  = 5'b11100;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_GES  = 5'b11101;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_LTU  = 5'b11110;
    localparam logic [ALU_CODE_WIDTH-1:0] ALU_GEU  = 5'b11111;

    localparam logic [1:0] TYPE_A_RD1  = 2'd0;
    localparam logic [1:0] TYPE_A_PC   = 2'd1;
    localparam logic [1:0] TYPE_A_ZERO = 2'd2;

    localparam logic [2:0] TYPE_B_RD2     = 3'd0;
    localparam logic [2:0] TYPE_B_IMM_I   = 3'd1;
    localparam logic [2:0] TYPE_B_IMM_U   = 3'd2;
    localparam logic [2:0] TYPE_B_IMM_S   = 3'd3;
    localparam logic [2:0] TYPE_B_PC_INCR = 3'd4;

    localparam logic [2:0] DATA_SIZE_BYTE  = 3'd0;
    localparam logic [2:0] DATA_SIZE_HALF  = 3'd1;
    localparam logic [2:0] DATA_SIZE_WORD  = 3'd2;
    localparam logic [2:0] DATA_SIZE_UBYTE = 3'd4;
    localparam logic [2:0] DATA_SIZE_UHALF = 3'd5;

    localparam logic WRITEBACK_RESULT = 1'b0;
    localparam logic WRITEBACK_DATA   = 1'b1;

    typedef struct packed {
        logic [1:0]                operandA;
        logic [2:0]                operandB;
        logic [ALU_CODE_WIDTH-1:0] aluOp;
        logic                      memReq;
        logic                      memWe;
        logic [2:0]                memSize;
        logic                      rfWe;
        logic                      wbType;
        logic                      branch;
        logic                      jal;
        logic                      jalr;
    } ctrl_t;

    // The control word every instruction starts from, and the one illegal decodes collapse to.
    function automatic ctrl_t defaultCtrl();
        ctrl_t c;
        c.operandA = TYPE_A_RD1;
        c.operandB = TYPE_B_IMM_I;
        c.aluOp    = ALU_ADD;
        c.memReq   = 1'b0;
        c.memWe    = 1'b0;
        c.memSize  = DATA_SIZE_WORD;
        c.rfWe     = 1'b0;
        c.wbType   = WRITEBACK_RESULT;
        c.branch   = 1'b0;
        c.jal      = 1'b0;
        c.jalr     = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/riscv_main_decoder_alu_op_decoder.sv
// Maps (opcode, func3, func7) to an ALU code and flags func3/func7 encodings that are
// reserved for the given opcode. Opcode validity itself is judged by the parent.
module alu_op_decoder
    import riscv_main_decoder_pkg::*;
(
    input  logic [4:0]                opcode,
    input  logic [2:0]                func3,
    input  logic [6:0]                func7,
    output logic [ALU_CODE_WIDTH-1:0] aluOp,
    output logic                      fieldIllegal
);

    always_comb begin
        // NOTE: both outputs are assigned before the case so no branch can infer a latch.
        aluOp        = ALU_ADD;
        fieldIllegal = 1'b0;
        case (opcode)
            OPCODE_OP_IMM: begin
                case (func3)
                    3'd0: aluOp = ALU_ADD;
                    3'd1: begin
                        aluOp        = ALU_SLL;
                        fieldIllegal = (func7 != FUNC7_BASE);
                    end
                    3'd2: aluOp = ALU_SLTS;
                    3'd3: aluOp = ALU_SLTU;
                    3'd4: aluOp = ALU_XOR;
                    3'd5: begin
                        if (func7 == FUNC7_BASE)     aluOp = ALU_SRL;
                        else if (func7 == FUNC7_ALT) aluOp = ALU_SRA;
                        else                         fieldIllegal = 1'b1;
                    end
                    3'd6: aluOp = ALU_OR;
                    3'd7: aluOp = ALU_AND;
                endcase
            end
            OPCODE_OP: begin
                if (func7 == FUNC7_BASE) begin
                    case (func3)
                        3'd0: aluOp = ALU_ADD;
                        3'd1: aluOp = ALU_SLL;
                        3'd2: aluOp = ALU_SLTS;
                        3'd3: aluOp = ALU_SLTU;
                        3'd4: aluOp = ALU_XOR;
                        3'd5: aluOp = ALU_SRL;
                        3'd6: aluOp = ALU_OR;
                        3'd7: aluOp = ALU_AND;
                    endcase
                end else if (func7 == FUNC7_ALT && func3 == 3'd0) begin
                    aluOp = ALU_SUB;
                end else if (func7 == FUNC7_ALT && func3 == 3'd5) begin
                    aluOp = ALU_SRA;
                end else begin
                    fieldIllegal = 1'b1;
                end
            end
            OPCODE_BRANCH: begin
                case (func3)
                    3'd0: aluOp = ALU_EQ;
                    3'd1: aluOp = ALU_NE;
                    3'd4: aluOp = ALU_LTS;
                    3'd5: aluOp = ALU_GES;
                    3'd6: aluOp = ALU_LTU;
                    3'd7: aluOp = ALU_GEU;
                    default: fieldIllegal = 1'b1;
                endcase
            end
            // Loads have no size encoding for func3 3, 6 or 7; stores only go up to a word.
            OPCODE_LOAD:  fieldIllegal = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
            OPCODE_STORE: fieldIllegal = (func3 > 3'd2);
            OPCODE_JALR:  fieldIllegal = (func3 != 3'd0);
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_main_decoder.sv
// RV32I main decoder: combinational datapath controls from the opcode fields, plus a sticky
// flag recording that an illegal instruction has been decoded since the last reset.
module riscv_main_decoder
    import riscv_main_decoder_pkg::*;
#(
    parameter int ALU_OP_WIDTH = ALU_CODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              opcode_type,
    input  logic [4:0]              opcode,
    input  logic [2:0]              func3,
    input  logic [6:0]              func7,
    output logic [1:0]              operand_A_type,
    output logic [2:0]              operand_B_type,
    output logic [ALU_OP_WIDTH-1:0] alu_operation,
    output logic                    memory_require,
    output logic                    memory_write_enable,
    output logic [2:0]              memory_size,
    output logic                    reg_file_write_enable,
    output logic                    reg_file_write_data_type,
    output logic                    illegal_flag,
    output logic                    branch_flag,
    output logic                    jal_flag,
    output logic                    jalr_flag,
    output logic                    illegal_seen
);

    logic [ALU_CODE_WIDTH-1:0] fieldAluOp;
    logic                      fieldIllegal;
    logic                      opcodeKnown;
    logic                      isIllegal;
    ctrl_t                     ctrl;

    alu_op_decoder aluOpDecoder (
        .opcode       (opcode),
        .func3        (func3),
        .func7        (func7),
        .aluOp        (fieldAluOp),
        .fieldIllegal (fieldIllegal)
    );

    always_comb begin
        ctrl        = defaultCtrl();
        opcodeKnown = 1'b1;
        case (opcode)
            OPCODE_LOAD: begin
                ctrl.memReq  = 1'b1;
                ctrl.memSize = func3;
                ctrl.rfWe    = 1'b1;
                ctrl.wbType  = WRITEBACK_DATA;
            end
            OPCODE_STORE: begin
                ctrl.operandB = TYPE_B_IMM_S;
                ctrl.memReq   = 1'b1;
                ctrl.memWe    = 1'b1;
                ctrl.memSize  = func3;
            end
            OPCODE_OP_IMM: begin
                ctrl.aluOp = fieldAluOp;
                ctrl.rfWe  = 1'b1;
            end
            OPCODE_OP: begin
                ctrl.operandB = TYPE_B_RD2;
                ctrl.aluOp    = fieldAluOp;
                ctrl.rfWe     = 1'b1;
            end
            OPCODE_LUI: begin
                ctrl.operandA = TYPE_A_ZERO;
                ctrl.operandB = TYPE_B_IMM_U;
                ctrl.rfWe     = 1'b1;
            end
            OPCODE_AUIPC: begin
                ctrl.operandA = TYPE_A_PC;
                ctrl.operandB = TYPE_B_IMM_U;
                ctrl.rfWe     = 1'b1;
            end
            OPCODE_BRANCH: begin
                ctrl.operandB = TYPE_B_RD2;
                ctrl.aluOp    = fieldAluOp;
                ctrl.branch   = 1'b1;
            end
            OPCODE_JAL: begin
                ctrl.operandA = TYPE_A_PC;
                ctrl.operandB = TYPE_B_PC_INCR;
                ctrl.rfWe     = 1'b1;
                ctrl.jal      = 1'b1;
            end
            OPCODE_JALR: begin
                ctrl.operandA = TYPE_A_PC;
                ctrl.operandB = TYPE_B_PC_INCR;
                ctrl.rfWe     = 1'b1;
                ctrl.jalr     = 1'b1;
            end
            OPCODE_MISC_MEM, OPCODE_SYSTEM: ;
            default: opcodeKnown = 1'b0;
        endcase

        isIllegal = (opcode_type != OPCODE_TYPE_32BIT) || !opcodeKnown || fieldIllegal;
        // An illegal instruction must not touch architectural state, so it gets a clean control word.
        if (isIllegal) begin
            ctrl = defaultCtrl();
        end
    end

    assign operand_A_type           = ctrl.operandA;
    assign operand_B_type           = ctrl.operandB;
    assign alu_operation            = ALU_OP_WIDTH'(ctrl.aluOp);
    assign memory_require           = ctrl.memReq;
    assign memory_write_enable      = ctrl.memWe;
    assign memory_size              = ctrl.memSize;
    assign reg_file_write_enable    = ctrl.rfWe;
    assign reg_file_write_data_type = ctrl.wbType;
    assign branch_flag              = ctrl.branch;
    assign jal_flag                 = ctrl.jal;
    assign jalr_flag                = ctrl.jalr;
    assign illegal_flag             = isIllegal;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so this behaves as a flop whatever order blocks evaluate in.
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (isIllegal) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_main_decoder.sv
// Scoreboard bench for riscv_main_decoder: the driver pushes hand-computed expectations,
// the monitor pops and compares one entry per applied instruction on the falling edge.
module tb_riscv_main_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] opcode_type;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [1:0] operand_A_type;
    logic [2:0] operand_B_type;
    logic [4:0] alu_operation;
    logic       memory_require;
    logic       memory_write_enable;
    logic [2:0] memory_size;
    logic       reg_file_write_enable;
    logic       reg_file_write_data_type;
    logic       illegal_flag;
    logic       branch_flag;
    logic       jal_flag;
    logic       jalr_flag;
    logic       illegal_seen;

    riscv_main_decoder #(.ALU_OP_WIDTH(5)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .opcode_type              (opcode_type),
        .opcode                   (opcode),
        .func3                    (func3),
        .func7                    (func7),
        .operand_A_type           (operand_A_type),
        .operand_B_type           (operand_B_type),
        .alu_operation            (alu_operation),
        .memory_require           (memory_require),
        .memory_write_enable      (memory_write_enable),
        .memory_size              (memory_size),
        .reg_file_write_enable    (reg_file_write_enable),
        .reg_file_write_data_type (reg_file_write_data_type),
        .illegal_flag             (illegal_flag),
        .branch_flag              (branch_flag),
        .jal_flag                 (jal_flag),
        .jalr_flag                (jalr_flag),
        .illegal_seen             (illegal_seen)
    );

    // Expected response: {A, B, ALU, memReq, memWe, size, rfWe, dataType, illegal, branch, jal, jalr, seen}
    typedef struct {
        string       name;
        logic [21:0] value;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   nCompared;
    int   nMismatched;
    logic sticky;
    logic [21:0] actual;

    localparam logic [4:0] ADD = 5'b00000, SLTU = 5'b00011, AND_ = 5'b00111, SUB = 5'b01000;
    localparam logic [4:0] SRA = 5'b01101, EQ = 5'b11000, GEU = 5'b11111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cur    = expQ.pop_front();
            actual = {operand_A_type, operand_B_type, alu_operation, memory_require,
                      memory_write_enable, memory_size, reg_file_write_enable,
                      reg_file_write_data_type, illegal_flag, branch_flag, jal_flag,
                      jalr_flag, illegal_seen};
            nCompared++;
            if (actual !== cur.value) begin
                nMismatched++;
                $display("FAIL %s: got %b expected %b (A,B,ALU,req,we,size,rfwe,dt,ill,br,jal,jalr,seen)",
                         cur.name, actual, cur.value);
            end
        end
    end

    // Drive one instruction just after a rising edge and queue what it must decode to.
    task automatic apply(input string name, input logic [31:0] instr,
                         input logic [1:0] a, input logic [2:0] b, input logic [4:0] alu,
                         input logic req, input logic we, input logic [2:0] size,
                         input logic rfWe, input logic dt, input logic ill, input logic br,
                         input logic jal, input logic jalr, input bit pulseReset);
        exp_t e;
        @(posedge clk);
        #1;
        opcode_type = instr[1:0];
        opcode      = instr[6:2];
        func3       = instr[14:12];
        func7       = instr[31:25];
        if (pulseReset) begin
            #1;
            rst_n  = 1'b0;
            sticky = 1'b0;
        end
        e.name  = name;
        e.value = {a, b, alu, req, we, size, rfWe, dt, ill, br, jal, jalr, sticky};
        expQ.push_back(e);
        sticky = sticky | ill;
        if (pulseReset) begin
            @(negedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic applyIllegal(input string name, input logic [31:0] instr);
        apply(name, instr, 2'd0, 3'd1, ADD, 0, 0, 3'd2, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        sticky      = 1'b0;
        rst_n       = 1'b0;
        opcode_type = 2'b11;
        opcode      = 5'b00100;
        func3       = 3'd0;
        func7       = 7'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        //        name           instr         A     B     ALU   req we size  rf dt il br jl jr rst
        apply("addi",        32'h00A00093, 2'd0, 3'd1, ADD,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("addi_f7",     32'hFFF00093, 2'd0, 3'd1, ADD,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("sltiu",       32'h0010B093, 2'd0, 3'd1, SLTU, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("srai",        32'h4010D093, 2'd0, 3'd1, SRA,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("lw",          32'h0000A103, 2'd0, 3'd1, ADD,  1, 0, 3'd2, 1, 1, 0, 0, 0, 0, 0);
        apply("lbu",         32'h0000C103, 2'd0, 3'd1, ADD,  1, 0, 3'd4, 1, 1, 0, 0, 0, 0, 0);
        apply("sw",          32'h0020A023, 2'd0, 3'd3, ADD,  1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        apply("sub",         32'h40208033, 2'd0, 3'd0, SUB,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("and",         32'h0020F0B3, 2'd0, 3'd0, AND_, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("sra",         32'h4020D0B3, 2'd0, 3'd0, SRA,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("beq",         32'h00208463, 2'd0, 3'd0, EQ,   0, 0, 3'd2, 0, 0, 0, 1, 0, 0, 0);
        apply("bgeu",        32'h0020F463, 2'd0, 3'd0, GEU,  0, 0, 3'd2, 0, 0, 0, 1, 0, 0, 0);
        apply("jal",         32'h0000006F, 2'd1, 3'd4, ADD,  0, 0, 3'd2, 1, 0, 0, 0, 1, 0, 0);
        apply("jalr",        32'h00008067, 2'd1, 3'd4, ADD,  0, 0, 3'd2, 1, 0, 0, 0, 0, 1, 0);
        apply("lui",         32'h123450B7, 2'd2, 3'd2, ADD,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("auipc",       32'h00001097, 2'd1, 3'd2, ADD,  0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        apply("fence",       32'h0000000F, 2'd0, 3'd1, ADD,  0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        apply("ecall",       32'h00000073, 2'd0, 3'd1, ADD,  0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 0);

        applyIllegal("addi_optype10", 32'h00A00092);
        applyIllegal("lw_f3_3",       32'h0000B103);
        applyIllegal("sw_f3_4",       32'h0020C023);
        applyIllegal("slli_f7_20",    32'h40109093);
        applyIllegal("jalr_f3_1",     32'h00001067);
        applyIllegal("branch_f3_2",   32'h0020A463);
        applyIllegal("op_f7_01",      32'h02208033);
        applyIllegal("opcode_11111",  32'h0000007F);

        apply("addi_rst_mid", 32'h00A00093, 2'd0, 3'd1, ADD, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 1);
        apply("addi_post_rst", 32'h00A00093, 2'd0, 3'd1, ADD, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        applyIllegal("opcode_after_rst", 32'h0000007F);
        apply("addi_seen_again", 32'h00A00093, 2'd0, 3'd1, ADD, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("FAIL queue_drain: got %0d pending entries expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
